// File: rtl/traffic_pkg.sv
// Shared constants and types for the traffic sensor conditioner.
// Holds the emergency FSM encoding and the default timing parameters.
package traffic_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        HOLD   = 2'd2
    } emrg_state_t;

    localparam int DEB_CYCLES_DEF = 8;
    localparam int EMRG_HOLD_DEF  = 30;
    localparam int NUM_LANES      = 4;

    function automatic logic [2:0] popcount4(input logic [3:0] v);
        return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
    endfunction

endpackage

// File: rtl/sensor_debounce.sv
// One lane: two-flop synchronizer, disagreement counter and output flop.
// The output flips only after DEB_CYCLES consecutive synchronized samples that differ from it.
module sensor_debounce #(
    parameter int DEB_CYCLES = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic sensor
);

    logic       meta;
    logic       sync;
    logic [7:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta   <= 1'b0;
            sync   <= 1'b0;
            cnt    <= '0;
            sensor <= 1'b0;
        end else begin
            meta <= raw;
            sync <= meta;
            // Any agreeing sample restarts the count, so short glitches never toggle.
            if (sync == sensor) begin
                cnt <= '0;
            end else if (cnt == 8'(DEB_CYCLES - 1)) begin
                cnt    <= '0;
                sensor <= ~sensor;
            end else begin
                cnt <= cnt + 8'd1;
            end
        end
    end

endmodule

// File: rtl/traffic_sensor_conditioner.sv
// Conditions raw lane detectors and priority requests for traffic_system.
// Four debounced lanes, an emergency hold FSM, prioritized alerts and a lane count.
module traffic_sensor_conditioner
    import traffic_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEF,
    parameter int EMRG_HOLD  = EMRG_HOLD_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       raw_north,
    input  logic       raw_east,
    input  logic       raw_south,
    input  logic       raw_west,
    input  logic       raw_emrg,
    input  logic       raw_alert1,
    input  logic       raw_alert2,
    output logic       sensor_north,
    output logic       sensor_east,
    output logic       sensor_south,
    output logic       sensor_west,
    output logic       emrg,
    output logic       alert1,
    output logic       alert2,
    output logic [2:0] lane_cnt
);

    logic [NUM_LANES-1:0] lane_raw;
    logic [NUM_LANES-1:0] lane_sensor;

    assign lane_raw = {raw_west, raw_south, raw_east, raw_north};

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        sensor_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
            .clk    (clk),
            .rst    (rst),
            .raw    (lane_raw[i]),
            .sensor (lane_sensor[i])
        );
    end

    assign sensor_north = lane_sensor[0];
    assign sensor_east  = lane_sensor[1];
    assign sensor_south = lane_sensor[2];
    assign sensor_west  = lane_sensor[3];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) lane_cnt <= '0;
        else      lane_cnt <= popcount4(lane_sensor);
    end

    // Priority request synchronizers: bit 0 emrg, bit 1 alert1, bit 2 alert2.
    logic [2:0] pri_meta;
    logic [2:0] pri_sync;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pri_meta <= '0;
            pri_sync <= '0;
        end else begin
            pri_meta <= {raw_alert2, raw_alert1, raw_emrg};
            pri_sync <= pri_meta;
        end
    end

    emrg_state_t state;
    logic [7:0]  hold_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            hold_cnt <= '0;
            emrg     <= 1'b0;
            alert1   <= 1'b0;
            alert2   <= 1'b0;
        end else begin
            // Alerts pass through only on cycles where the FSM ends up IDLE.
            alert1 <= pri_sync[1];
            alert2 <= pri_sync[2] & ~pri_sync[1];
            case (state)
                IDLE: begin
                    if (pri_sync[0]) begin
                        state  <= ACTIVE;
                        emrg   <= 1'b1;
                        alert1 <= 1'b0;
                        alert2 <= 1'b0;
                    end
                end
                ACTIVE: begin
                    alert1 <= 1'b0;
                    alert2 <= 1'b0;
                    if (!pri_sync[0]) begin
                        state    <= HOLD;
                        hold_cnt <= 8'(EMRG_HOLD - 1);
                    end
                end
                HOLD: begin
                    if (pri_sync[0]) begin
                        state  <= ACTIVE;
                        alert1 <= 1'b0;
                        alert2 <= 1'b0;
                    end else if (hold_cnt == 8'd0) begin
                        state <= IDLE;
                        emrg  <= 1'b0;
                    end else begin
                        hold_cnt <= hold_cnt - 8'd1;
                        alert1   <= 1'b0;
                        alert2   <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    emrg  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_traffic_sensor_conditioner.sv
// Randomized scoreboard bench for traffic_sensor_conditioner.
// The reference model works from sample windows and request age, not from counters or FSM states.
module tb_traffic_sensor_conditioner;

    localparam int DEB  = 8;
    localparam int HOLD = 30;
    localparam int NCYC = 3000;

    typedef struct packed {
        logic [3:0] sens;
        logic       emrg;
        logic       a1;
        logic       a2;
        logic [2:0] cnt;
    } obs_t;

    logic clk = 1'b0;
    logic rst;
    logic [6:0] raw;
    logic s_n, s_e, s_s, s_w, emrg, alert1, alert2;
    logic [2:0] lane_cnt;

    always #5 clk = ~clk;

    traffic_sensor_conditioner #(.DEB_CYCLES(DEB), .EMRG_HOLD(HOLD)) dut (
        .clk          (clk),
        .rst          (rst),
        .raw_north    (raw[0]),
        .raw_east     (raw[1]),
        .raw_south    (raw[2]),
        .raw_west     (raw[3]),
        .raw_emrg     (raw[4]),
        .raw_alert1   (raw[5]),
        .raw_alert2   (raw[6]),
        .sensor_north (s_n),
        .sensor_east  (s_e),
        .sensor_south (s_s),
        .sensor_west  (s_w),
        .emrg         (emrg),
        .alert1       (alert1),
        .alert2       (alert2),
        .lane_cnt     (lane_cnt)
    );

    int errors = 0;
    int checks = 0;
    obs_t exp_q[$];

    // Reference model state
    logic [6:0]     d1, d2;
    logic [3:0]     m_sens;
    logic [DEB-1:0] hist [4];
    int             nval [4];
    int             age;
    bit             seen;
    obs_t           m_out;

    function automatic obs_t dut_obs();
        obs_t o;
        o.sens = {s_w, s_s, s_e, s_n};
        o.emrg = emrg;
        o.a1   = alert1;
        o.a2   = alert2;
        o.cnt  = lane_cnt;
        return o;
    endfunction

    task automatic model_reset();
        d1 = '0; d2 = '0; m_sens = '0; age = 0; seen = 0; m_out = '0;
        for (int i = 0; i < 4; i++) begin
            hist[i] = '0;
            nval[i] = 0;
        end
    endtask

    // Outputs expected just after one rising edge, given raw as sampled by that edge.
    task automatic model_step(input logic [6:0] r);
        logic [6:0] s;
        logic [DEB-1:0] all_off;
        s = d2; d2 = d1; d1 = r;
        m_out.cnt = 3'($countones(m_sens));
        for (int i = 0; i < 4; i++) begin
            hist[i] = {hist[i][DEB-2:0], s[i]};
            if (nval[i] < DEB) nval[i]++;
            all_off = {DEB{~m_sens[i]}};
            if (nval[i] == DEB && hist[i] == all_off) begin
                m_sens[i] = ~m_sens[i];
                nval[i] = 0;
            end
        end
        m_out.sens = m_sens;
        if (s[4]) begin
            seen = 1; age = 0;
        end else if (age < 1000) begin
            age++;
        end
        m_out.emrg = seen && (age <= HOLD);
        m_out.a1 = !m_out.emrg && s[5];
        m_out.a2 = !m_out.emrg && s[6] && !s[5];
    endtask

    task automatic check_zero(input string name);
        obs_t o;
        o = dut_obs();
        checks++;
        if (o != '0) begin
            errors++;
            $display("FAIL %s: got %h expected 0", name, o);
        end
    endtask

    // Monitor: outputs change every cycle, so one expectation is consumed per falling edge.
    initial begin
        obs_t e, o;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                o = dut_obs();
                checks++;
                if (o !== e) begin
                    errors++;
                    $display("FAIL outputs @%0t: got sens=%b emrg=%b a1=%b a2=%b cnt=%0d expected sens=%b emrg=%b a1=%b a2=%b cnt=%0d",
                             $time, o.sens, o.emrg, o.a1, o.a2, o.cnt,
                             e.sens, e.emrg, e.a1, e.a2, e.cnt);
                end
            end
        end
    end

    initial begin
        int mode;
        rst = 1'b0;
        raw = '0;
        model_reset();
        #1 check_zero("reset_initial");
        repeat (3) @(posedge clk);
        #1 check_zero("reset_held");
        @(negedge clk);
        #1 rst = 1'b1;
        mode = 0;
        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(posedge clk);
            if (!rst) begin
                model_reset();
                exp_q.push_back('0);
            end else begin
                model_step(raw);
                exp_q.push_back(m_out);
            end
            #2;
            if (cyc % 200 == 0) mode = $urandom_range(0, 2);
            if (cyc < 40) begin
                raw[0] = 1'b1;                      // clean north rise first
            end else begin
                for (int i = 0; i < 4; i++)
                    if ($urandom_range(0, (mode == 1) ? 4 : 15) == 0) raw[i] = ~raw[i];
            end
            if ($urandom_range(0, (mode == 2) ? 8 : 35) == 0) raw[4] = ~raw[4];
            if ($urandom_range(0, 7) == 0) raw[5] = ~raw[5];
            if ($urandom_range(0, 7) == 0) raw[6] = ~raw[6];
            if (cyc == 1200 || cyc == 2400) begin
                @(negedge clk);
                #1 rst = 1'b0;
                #1 check_zero("reset_async");
            end
            if (cyc == 1203 || cyc == 2403) begin
                @(negedge clk);
                #1 rst = 1'b1;
            end
        end
        @(negedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/traffic_sensor_conditioner.md
TRAFFIC_SENSOR_CONDITIONER -- requirements
Module: traffic_sensor_conditioner

Interface
REQ-001 SHALL have parameter DEB_CYCLES, default 8: consecutive disagreeing cycles needed before a debounced sensor output toggles (range 2..255).
REQ-002 SHALL have parameter EMRG_HOLD, default 30: cycles emrg stays asserted after the synchronized request drops (range 1..255).
REQ-003 SHALL have port clk  in  1  single system clock, all flops rising-edge.
REQ-004 SHALL have port rst  in  1  asynchronous active-low reset.
REQ-005 SHALL have ports raw_north, raw_east, raw_south, raw_west  in  1 each  asynchronous lane vehicle detectors.
REQ-006 SHALL have ports raw_emrg, raw_alert1, raw_alert2  in  1 each  asynchronous emergency/ambulance/police requests.
REQ-007 SHALL have ports sensor_north, sensor_east, sensor_south, sensor_west  out  1 each  debounced lane occupancy to traffic_system.
REQ-008 SHALL have ports emrg, alert1, alert2  out  1 each  conditioned priority requests to traffic_system.
REQ-009 SHALL have port lane_cnt  out  3  number of debounced sensor outputs currently 1 (0..4).

Function
REQ-010 SHALL pass every raw_* input through a two-flop synchronizer before any other logic.
REQ-011 SHALL keep per lane an 8-bit counter: reset to 0 when synchronized value equals output; otherwise increment.
REQ-012 SHALL toggle a lane output and clear its counter on the cycle the counter would reach DEB_CYCLES, i.e. after DEB_CYCLES consecutive disagreeing cycles.
REQ-013 SHALL give total latency from a clean raw change to sensor output change of exactly DEB_CYCLES+2 rising edges.
REQ-014 SHALL reject glitches shorter than DEB_CYCLES synchronized cycles with no output change; a single agreeing cycle restarts the count.
REQ-015 SHALL implement emergency FSM states IDLE, ACTIVE, HOLD; emrg output = 1 in ACTIVE and HOLD, 0 in IDLE.
REQ-016 SHALL transition IDLE->ACTIVE on synchronized raw_emrg = 1; ACTIVE->HOLD when synchronized raw_emrg = 0, loading hold counter with EMRG_HOLD-1.
REQ-017 SHALL in HOLD decrement the hold counter each cycle, go HOLD->IDLE on the cycle it is 0, and go HOLD->ACTIVE immediately if synchronized raw_emrg returns to 1 (counter reloaded on next exit from ACTIVE).
REQ-018 SHALL register alert outputs: alert1 = synced raw_alert1; alert2 = synced raw_alert2 AND NOT synced raw_alert1 (alert1 wins when simultaneous).
REQ-019 SHALL force alert1 = alert2 = 0 while the emergency FSM is not IDLE (emergency outranks both alerts).
REQ-020 SHALL register lane_cnt from the debounced outputs, one cycle after them; never exceed 4, no wrap.
REQ-021 SHALL make all outputs registered; no combinational path from any raw_* input to any output.

Reset
REQ-022 SHALL on rst = 0, asynchronously, clear synchronizers, debounce counters, hold counter, all outputs to 0 and the FSM to IDLE.
REQ-023 SHALL on a reset during ACTIVE/HOLD drop emrg immediately; after release, re-enter ACTIVE only via REQ-016 (synchronized request still high -> emrg at 3rd edge after release).
REQ-024 SHALL after release treat debounced sensors as 0, so a lane held at 1 asserts after DEB_CYCLES+2 edges.

Structure
REQ-025 SHALL place FSM state encoding (IDLE=2'd0, ACTIVE=2'd1, HOLD=2'd2) and default DEB_CYCLES/EMRG_HOLD constants in shared package traffic_pkg.
REQ-026 SHALL implement debounce as sub-module sensor_debounce (synchronizer + counter + output flop, parameter DEB_CYCLES), instantiated four times.

Verification
REQ-027 SHALL cover: raw_north 0->1 held, DEB_CYCLES=8 -> sensor_north rises at edge 10, lane_cnt = 1 at edge 11.
REQ-028 SHALL cover: raw_east 5-cycle pulse, then 1-cycle drop inside a 12-cycle high -> sensor_east stays 0 for pulse; rises only 10 edges after the drop ends.
REQ-029 SHALL cover: raw_emrg high 3 cycles, EMRG_HOLD=30 -> emrg high from edge 3 through HOLD, low exactly 30 cycles after ACTIVE exits.
REQ-030 SHALL cover: raw_emrg re-asserted at hold count 10 -> FSM to ACTIVE, emrg never drops, full 30-cycle hold after second release.
REQ-031 SHALL cover: raw_alert1 = raw_alert2 = 1 -> alert1 = 1, alert2 = 0; assert raw_emrg -> both alerts 0 while emrg = 1.
REQ-032 SHALL cover: rst = 0 mid-HOLD with all four lanes active -> all outputs 0 same cycle, lane_cnt = 0; after release lanes return after 10 edges.
